// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// saturating arithmetic helpers.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_ctr_e;

    localparam logic [1:0]  BHT_RESET = 2'(WNT);
    localparam int unsigned STAT_W    = 32;

    // Count up, holding at strongly-taken.
    function automatic logic [1:0] sat_inc2(input logic [1:0] c);
        return (c == 2'(ST)) ? c : c + 2'd1;
    endfunction

    // Count down, holding at strongly-not-taken.
    function automatic logic [1:0] sat_dec2(input logic [1:0] c);
        return (c == 2'(SNT)) ? c : c - 2'd1;
    endfunction

    // 32-bit statistic counter that sticks at all-ones.
    function automatic logic [STAT_W-1:0] sat_inc32(input logic [STAT_W-1:0] c);
        return (c == '1) ? c : c + STAT_W'(1);
    endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup port, one
// registered write port. Only the valid bits are reset.
module bp_btb #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16
) (
    input  logic            clk,
    input  logic            rst_n_i,
    input  logic [XLEN-1:0] lk_pc_i,
    output logic            lk_hit_o,
    output logic [XLEN-1:0] lk_target_o,
    input  logic            wr_en_i,
    input  logic [XLEN-1:0] wr_pc_i,
    input  logic [XLEN-1:0] wr_target_i
);

    localparam int unsigned IW = $clog2(ENTRIES);
    localparam int unsigned TW = XLEN - IW - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TW-1:0]      tag_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];

    logic [IW-1:0] lk_idx;
    logic [TW-1:0] lk_tag;
    logic [IW-1:0] wr_idx;
    logic [TW-1:0] wr_tag;
    logic          unused_pc_lsbs;

    assign lk_idx = lk_pc_i[IW+1:2];
    assign lk_tag = lk_pc_i[XLEN-1:IW+2];
    assign wr_idx = wr_pc_i[IW+1:2];
    assign wr_tag = wr_pc_i[XLEN-1:IW+2];

    // Instruction alignment bits never participate in index or tag.
    assign unused_pc_lsbs = ^{lk_pc_i[1:0], wr_pc_i[1:0]};

    // Hit on matching valid tag; otherwise fall through to sequential PC.
    assign lk_hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_target_o = lk_hit_o ? tgt_q[lk_idx] : lk_pc_i + XLEN'(4);

    // Valid bits: cleared on reset, set by any taken-branch write.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/target payload; contents are don't-care while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx] <= wr_tag;
            tgt_q[wr_idx] <= wr_target_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: 2-bit BHT + direct-mapped BTB, zero-latency
// lookup in IF, training and mispredict redirect from EX, saturating stats.
// Optional gshare indexing is enabled by defining BP_GSHARE_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned GHR_W       = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   if_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic              ex_taken,
    input  logic [XLEN-1:0]   ex_target,
    input  logic              ex_pred_taken,
    input  logic [XLEN-1:0]   ex_pred_target,
    output logic              redirect,
    output logic [XLEN-1:0]   redirect_pc,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispred
);

    localparam int unsigned BHT_IW = $clog2(BHT_ENTRIES);

    logic [1:0]        bht_q [BHT_ENTRIES];
    logic [1:0]        bht_d [BHT_ENTRIES];
    logic [STAT_W-1:0] stat_br_q, stat_br_d;
    logic [STAT_W-1:0] stat_mp_q, stat_mp_d;

    logic [BHT_IW-1:0] lk_idx;
    logic [BHT_IW-1:0] tr_idx;
    logic              res_c;
    logic              mispredict_c;
    logic              btb_hit;
    logic [XLEN-1:0]   btb_target;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    // Gshare: PC index folded with global history (pre-shift value for training).
    assign lk_idx = if_pc[BHT_IW+1:2] ^ BHT_IW'(ghr_q);
    assign tr_idx = ex_pc[BHT_IW+1:2] ^ BHT_IW'(ghr_q);

    // Shift the resolved direction into the history.
    always_comb begin
        ghr_d = ghr_q;
        if (res_c) begin
            ghr_d = {ghr_q[GHR_W-2:0], ex_taken};
        end
    end

    // Global history register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    localparam int unsigned UNUSED_GHR_W = GHR_W;

    // Bimodal: PC-only index.
    assign lk_idx = if_pc[BHT_IW+1:2];
    assign tr_idx = ex_pc[BHT_IW+1:2];
`endif

    bp_btb #(
        .XLEN    (XLEN),
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst_n_i     (reset),
        .lk_pc_i     (if_pc),
        .lk_hit_o    (btb_hit),
        .lk_target_o (btb_target),
        .wr_en_i     (res_c & ex_taken),
        .wr_pc_i     (ex_pc),
        .wr_target_i (ex_target)
    );

    // Fetch-side prediction; reads only state registered before this edge.
    assign pred_taken  = reset & btb_hit & bht_q[lk_idx][1];
    assign pred_target = btb_target;

    // EX-side resolution and mispredict detection.
    assign res_c        = ex_valid & ex_is_branch;
    assign mispredict_c = res_c & ((ex_taken != ex_pred_taken) |
                                   (ex_taken & (ex_target != ex_pred_target)));
    assign redirect     = reset & mispredict_c;
    assign redirect_pc  = ex_taken ? ex_target : ex_pc + XLEN'(4);

    // BHT and statistics next-state.
    always_comb begin
        bht_d     = bht_q;
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (res_c) begin
            bht_d[tr_idx] = ex_taken ? sat_inc2(bht_q[tr_idx]) : sat_dec2(bht_q[tr_idx]);
            stat_br_d     = sat_inc32(stat_br_q);
            if (mispredict_c) begin
                stat_mp_d = sat_inc32(stat_mp_q);
            end
        end
    end

    // BHT and statistics registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht_q[i] <= BHT_RESET;
            end
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else begin
            bht_q     <= bht_d;
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches = stat_br_q;
    assign stat_mispred  = stat_mp_q;

endmodule
